// File: rtl/mem_stall_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage stall controller.
// The slave modport is the controller; the master modport is the pipeline/memory environment.
interface mem_stall_ctrl_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] ReadData_o;
    logic        stall_o;
    logic        bubble_o;
    logic        err_o;
    logic [15:0] stall_cnt_o;

    modport slave (
        input  MemRead_i, MemWrite_i, Addr_i, WriteData_i, mem_ack_i, mem_rdata_i,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ReadData_o,
               stall_o, bubble_o, err_o, stall_cnt_o
    );

    modport master (
        output MemRead_i, MemWrite_i, Addr_i, WriteData_i, mem_ack_i, mem_rdata_i,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ReadData_o,
               stall_o, bubble_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/mem_stall_ctrl.sv
// MEM-stage stall controller: holds the pipeline while a load/store waits for a
// variable-latency data memory, with a timeout that abandons the access and flags an error.
module mem_stall_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    mem_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] scnt_q, scnt_d;
    logic        access;
    logic        stall;

    assign access = bus.MemRead_i | bus.MemWrite_i;
    // Gated by start_i so an asserted reset releases the pipeline in the same cycle.
    assign stall  = start_i & (((state_q == IDLE) & access) | (state_q == WAIT));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        scnt_d  = (stall && scnt_q != 16'hFFFF) ? scnt_q + 16'd1 : scnt_q;

        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    we_d    = bus.MemWrite_i;
                    addr_d  = bus.Addr_i;
                    wdata_d = bus.WriteData_i;
                    wcnt_d  = 8'd0;
                end
            end
            WAIT: begin
                // Ack takes priority over a coinciding timeout.
                if (bus.mem_ack_i) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = bus.mem_rdata_i;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= IDLE;
            wcnt_q  <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            scnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            scnt_q  <= scnt_d;
        end
    end

    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.ReadData_o  = rdata_q;
    assign bus.stall_o     = stall;
    assign bus.bubble_o    = stall;
    assign bus.err_o       = err_q;
    assign bus.stall_cnt_o = scnt_q;
endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles before an access is abandoned; legal range 2..255.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 start_i  in  1  reset; asynchronous, active-low.
REQ-004 MemRead_i  in  1  MEM-stage load request, from the EX/MEM register.
REQ-005 MemWrite_i  in  1  MEM-stage store request, from the EX/MEM register.
REQ-006 Addr_i  in  32  MEM-stage ALU address.
REQ-007 WriteData_i  in  32  MEM-stage store data.
REQ-008 mem_ack_i  in  1  data memory completion strobe, one cycle.
REQ-009 mem_rdata_i  in  32  data memory read data, valid when mem_ack_i=1.
REQ-010 mem_req_o  out  1  registered request to data memory.
REQ-011 mem_we_o  out  1  registered write enable; 1=store.
REQ-012 mem_addr_o  out  32  registered address.
REQ-013 mem_wdata_o  out  32  registered store data.
REQ-014 ReadData_o  out  32  registered load result; drives the MEM/WB ReadData input.
REQ-015 stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-016 bubble_o  out  1  forces the MEM/WB RegWrite and MemtoReg inputs to 0.
REQ-017 err_o  out  1  sticky timeout flag.
REQ-018 stall_cnt_o  out  16  saturating count of stalled cycles.

Function
REQ-019 The FSM SHALL have three states: IDLE, WAIT and DONE, encoded in 2 bits.
REQ-020 IDLE: if MemRead_i|MemWrite_i=1, the next state SHALL be WAIT, and Addr_i, WriteData_i and MemWrite_i SHALL be latched into mem_addr_o, mem_wdata_o and mem_we_o.
REQ-021 If MemRead_i=MemWrite_i=1, the access SHALL be treated as a store (mem_we_o=1), with no error.
REQ-022 mem_req_o SHALL be 1 in every WAIT cycle and 0 in IDLE and DONE; first assertion is exactly one cycle after the triggering IDLE cycle.
REQ-023 mem_addr_o, mem_wdata_o and mem_we_o SHALL remain constant throughout WAIT.
REQ-024 stall_o SHALL be combinational: 1 when (IDLE and (MemRead_i|MemWrite_i)) or WAIT; 0 in DONE.
REQ-025 bubble_o SHALL equal stall_o.
REQ-026 WAIT with mem_ack_i=1: the next state SHALL be DONE; if mem_we_o=0, ReadData_o SHALL load mem_rdata_i; ReadData_o SHALL be unchanged for stores.
REQ-027 WAIT: an 8-bit wait counter SHALL clear on entry and increment each WAIT cycle without ack.
REQ-028 WAIT without ack when the counter equals TIMEOUT-1: the next state SHALL be DONE, err_o SHALL set, and ReadData_o SHALL load 0.
REQ-029 If ack and timeout occur in the same cycle, ack SHALL win and err_o SHALL not set.
REQ-030 DONE SHALL last exactly one cycle and then return to IDLE; the pipeline advances at the DONE clock edge, so the completed instruction is not re-triggered.
REQ-031 mem_ack_i in IDLE or DONE SHALL be ignored, with no state or data change.
REQ-032 err_o SHALL clear only on reset.
REQ-033 stall_cnt_o SHALL increment on every cycle with stall_o=1 and hold at 16'hFFFF.
REQ-034 Access latency: a zero-wait memory (ack in the first WAIT cycle) SHALL give exactly 2 stalled cycles per access (IDLE-trigger and WAIT), then DONE.

Reset
REQ-035 start_i=0 SHALL force, asynchronously: state=IDLE, wait counter=0, and every registered output (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ReadData_o, err_o, stall_cnt_o) to 0.
REQ-036 Reset asserted during WAIT SHALL drop mem_req_o immediately; a later ack for the aborted access SHALL be ignored.
REQ-037 After start_i rises, the first triggering access SHALL be accepted on the next rising edge.

Verification
REQ-038 Load, Addr_i=0x40, ack in the 1st WAIT cycle with rdata 0x12345678 -> stall_o high 2 cycles, ReadData_o=0x12345678 in DONE, stall_cnt_o=2.
REQ-039 Store, Addr_i=0x80, WriteData_i=0xCAFEF00D, ack after 3 WAIT cycles -> mem_we_o=1, address and data stable for 3 cycles, stall_o high 4 cycles, ReadData_o unchanged.
REQ-040 Load, no ack, TIMEOUT=16 -> DONE after 16 WAIT cycles, err_o=1 (stays 1), ReadData_o=0.
REQ-041 Ack in the same cycle the counter hits TIMEOUT-1 -> data captured, err_o=0.
REQ-042 start_i pulled low in the 2nd WAIT cycle -> mem_req_o=0 and stall_o=0 immediately, all outputs 0; a subsequent stray ack causes no change.
REQ-043 Back-to-back loads in consecutive instructions -> two separate IDLE-WAIT-DONE sequences, with exactly one non-stalled DONE cycle between them.
